// File: rtl/mux_nch_rr.sv
// mux_nch_rr: N-channel valid/ready multiplexer with a one-word output register.
// Two selection modes share the same datapath:
//   mode=0 : fixed select, the channel named by 'sel' (out-of-range sel selects nothing)
//   mode=1 : round-robin, first valid channel at or after 'ptr', wrapping
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   in_data  [NUM_IN*WIDTH] - packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid [NUM_IN]     - per-channel offer
//   in_ready [NUM_IN]     - one-hot (or zero) transfer grant, combinational
//   sel, mode             - selection controls
//   out_data, out_chan, out_valid / out_ready - registered output handshake
//   xfer_count [16]       - wrapping count of accepted input words
module mux_nch_rr #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_count
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] candIdx;
    logic             candFound;
    logic             canLoad;
    logic             xfer;
    logic [WIDTH-1:0] selWord;
    logic [SEL_W-1:0] ptrNext;

    assign canLoad = !out_valid || out_ready;

    // Candidate choice. Round-robin is done as two descending sweeps so the
    // lowest index wins each: the first finds the lowest valid channel overall
    // (the wrap-around case), the second overrides it with the lowest valid
    // channel at or above ptr when one exists.
    always_comb begin
        candFound = 1'b0;
        candIdx   = '0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    candFound = 1'b1;
                    candIdx   = SEL_W'(i);
                end
            end
        end else begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    candFound = 1'b1;
                    candIdx   = SEL_W'(i);
                end
            end
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_valid[i] && SEL_W'(i) >= ptr) begin
                    candIdx = SEL_W'(i);
                end
            end
        end
    end

    assign xfer = candFound && canLoad && !reset;

    always_comb begin
        in_ready = '0;
        selWord  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (candIdx == SEL_W'(i)) begin
                in_ready[i] = xfer;
                selWord     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptrNext = (candIdx == SEL_W'(NUM_IN - 1)) ? '0 : candIdx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            ptr        <= '0;
            xfer_count <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= selWord;
            out_chan   <= candIdx;
            ptr        <= ptrNext;
            xfer_count <= xfer_count + 16'd1;
        end else if (canLoad) begin
            // Drained with nothing to replace it; data/chan keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_nch_rr.md
MUX_NCH_RR -- requirements
Module: mux_nch_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel in bits.
REQ-002 SHALL have parameter NUM_IN, default 5: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 3: select/channel-index width; ceil(log2(NUM_IN)) <= SEL_W <= 4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, NUM_IN*WIDTH: channel i at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 SHALL have port in_valid, input, NUM_IN: bit i high means channel i offers a word.
REQ-008 SHALL have port in_ready, output, NUM_IN: bit i high means channel i's word transfers this cycle if valid.
REQ-009 SHALL have port sel, input, SEL_W: channel index used in fixed mode.
REQ-010 SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-011 SHALL have port out_data, output, WIDTH: registered selected word.
REQ-012 SHALL have port out_chan, output, SEL_W: index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1: out_data/out_chan hold an unconsumed word.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the word this cycle.
REQ-015 SHALL have port xfer_count, output, 16: number of input transfers since reset.

Function
REQ-016 SHALL define can_load = !out_valid || out_ready (output register empty or draining this cycle).
REQ-017 In fixed mode, candidate channel c SHALL be sel if sel < NUM_IN and in_valid[sel]; otherwise no candidate (sel >= NUM_IN never selects any channel).
REQ-018 In round-robin mode, c SHALL be the first i with in_valid[i] high searching ptr, ptr+1, ..., wrapping modulo NUM_IN; no candidate if in_valid is all zero.
REQ-019 in_ready SHALL be combinational: in_ready[c] = can_load && candidate exists && !reset; all other bits 0; at most one bit high.
REQ-020 On a transfer (in_valid[c] && in_ready[c]) the next edge SHALL load out_data <= channel c word, out_chan <= c, out_valid <= 1, ptr <= (c+1) mod NUM_IN, xfer_count <= xfer_count+1 (wraps 0xFFFF -> 0x0000).
REQ-021 If can_load and no transfer, the next edge SHALL set out_valid <= 0; out_data and out_chan SHALL hold their values.
REQ-022 If out_valid && !out_ready, all output registers, ptr and xfer_count SHALL hold; in_ready SHALL be all zero (backpressure).
REQ-023 Latency SHALL be exactly 1 cycle from transfer edge to out_valid; simultaneous drain and load SHALL sustain one word per cycle.
REQ-024 ptr SHALL update only on transfers, in either mode; changing mode or sel SHALL affect only the current-cycle combinational choice, never the held output word.
REQ-025 in_data of non-selected channels SHALL have no effect on any output.

Reset
REQ-026 While reset is high at a clock edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0, xfer_count <= 0; reset SHALL override any concurrent transfer.
REQ-027 Reset asserted with out_valid high SHALL discard the held word; no transfer is counted in that cycle.

Verification (NUM_IN=5, WIDTH=32, SEL_W=3)
REQ-028 Fixed mode, sel=3, in_valid=5'b11111, ch3=0xDEADBEEF, out_ready=1 -> in_ready=5'b01000; next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=3, xfer_count=1.
REQ-029 Fixed mode, sel=5..7, all valid -> in_ready=0 every cycle; out_valid stays 0; xfer_count stays 0.
REQ-030 Round-robin, in_valid=5'b11111 held, out_ready=1, 7 cycles after reset -> out_chan sequence 0,1,2,3,4,0,1; xfer_count=7.
REQ-031 Round-robin, in_valid=5'b10010, out_ready=0 after first load -> out_chan=1 held with out_data stable, in_ready=0; release out_ready -> next out_chan=4, then 1.
REQ-032 Reset pulsed one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, xfer_count=0; first round-robin grant after reset goes to lowest valid index.
REQ-033 Force 65536 transfers -> xfer_count wraps to 0x0000 with no effect on data path.
